// File: rtl/peripheral_noc_demux.sv
// -----------------------------------------------------------------------------
// peripheral_noc_demux
//
// Packet-level demultiplexer placed directly upstream of the NoC channel mux.
// It splits one incoming flit stream into CHANNELS per-class streams. The
// header flit selects the destination channel through a bit field, and the
// whole packet (up to and including the flit with last=1) follows that route.
// A one-entry registered output stage decouples output timing from the input.
// A header whose channel index is out of range causes the whole packet to be
// discarded, and a single-cycle error pulse is raised.
//
// Parameters:
//   FLIT_WIDTH  flit data width in bits
//   CHANNELS    number of output channels (>= 2)
//   SEL_LSB     LSB position of the channel-select field in the header flit
//   SEL_WIDTH   width of the channel-select field (2**SEL_WIDTH >= CHANNELS)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   in_flit    input flit
//   in_last    input flit is the last flit of its packet
//   in_valid   input flit valid
//   in_ready   the block accepts the input flit this cycle
//   out_flit   per-channel output flit (all channels share the buffer data)
//   out_last   per-channel last flag (all channels share the buffer flag)
//   out_valid  one-hot or zero, set only on the buffered flit's channel
//   out_ready  per-channel downstream ready
//   drop_err   one-cycle registered pulse when an out-of-range header is taken
// -----------------------------------------------------------------------------
module peripheral_noc_demux #(
   parameter int FLIT_WIDTH = 32,
   parameter int CHANNELS   = 2,
   parameter int SEL_LSB    = 24,
   parameter int SEL_WIDTH  = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [FLIT_WIDTH-1:0]                in_flit,
   input  logic                                 in_last,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit,
   output logic [CHANNELS-1:0]                  out_last,
   output logic [CHANNELS-1:0]                  out_valid,
   input  logic [CHANNELS-1:0]                  out_ready,
   output logic                                 drop_err
);

   localparam int DEST_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   // HEAD: waiting for a header, BODY: forwarding a packet, DROP: discarding one
   typedef enum logic [1:0] {
      HEAD,
      BODY,
      DROP
   } state_t;

   state_t                state;
   logic [FLIT_WIDTH-1:0] buf_flit;
   logic                  buf_last;
   logic [DEST_W-1:0]     buf_dest;
   logic                  buf_valid;
   logic [DEST_W-1:0]     route;

   logic [SEL_WIDTH-1:0]  sel;
   logic                  sel_ok;
   logic                  drain;
   logic                  space;
   logic                  accept;
   logic                  load;
   logic [DEST_W-1:0]     load_dest;

   // Channel-select field of the current input flit; only meaningful in HEAD.
   assign sel    = in_flit[SEL_LSB +: SEL_WIDTH];
   assign sel_ok = (32'(sel) < CHANNELS);

   // Every channel sees the same buffer contents; only valid is steered.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_out
      assign out_valid[c] = buf_valid && (buf_dest == DEST_W'(c));
      assign out_flit[c]  = buf_flit;
      assign out_last[c]  = buf_last;
   end

   // out_valid is one-hot or zero, so this equals out_ready[buf_dest] when full.
   assign drain = |(out_valid & out_ready);

   // The buffer can take a new flit when empty or when it drains this cycle,
   // which keeps full throughput through the single output register.
   assign space = ~buf_valid | drain;

   // While dropping, flits never touch the buffer, so they are always taken.
   assign in_ready = (state == DROP) | space;
   assign accept   = in_valid & in_ready;

   // Body flits reuse the latched route; only headers are decoded.
   assign load      = accept & (((state == HEAD) & sel_ok) | (state == BODY));
   assign load_dest = (state == HEAD) ? DEST_W'(sel) : route;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values no matter how the block is ordered.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the single-entry buffer is a register, not a memory, so its
         // data is reset too; a stale flit can never reappear after reset.
         state     <= HEAD;
         buf_flit  <= '0;
         buf_last  <= 1'b0;
         buf_dest  <= '0;
         buf_valid <= 1'b0;
         route     <= '0;
         drop_err  <= 1'b0;
      end else begin
         drop_err <= accept && (state == HEAD) && !sel_ok;

         // A load wins over a drain: the entry is overwritten and stays valid.
         if (load) begin
            buf_flit  <= in_flit;
            buf_last  <= in_last;
            buf_dest  <= load_dest;
            buf_valid <= 1'b1;
         end else if (drain) begin
            buf_valid <= 1'b0;
         end

         if (accept) begin
            case (state)
               HEAD: begin
                  if (sel_ok) begin
                     route <= DEST_W'(sel);
                  end
                  if (in_last) begin
                     state <= HEAD;
                  end else begin
                     state <= sel_ok ? BODY : DROP;
                  end
               end
               BODY, DROP: begin
                  if (in_last) begin
                     state <= HEAD;
                  end
               end
               default: state <= HEAD;
            endcase
         end
      end
   end

endmodule
